pipelined_cla_subtractor: RTL
=============================

Name: pipelined_cla_subtractor

Overview:
- Pipelined signed/unsigned subtractor: D = A - B - Bin, computed as A + ~B + ~Bin.
- Uses segmented carry-lookahead; one SEG-bit segment is resolved per pipeline stage, with the carry registered between stages.
- Valid/ready handshake on both sides, so it drops into the datapath next to the existing adder as its streaming inverse-operation unit.
- Produces borrow, signed overflow and zero flags alongside the difference.

Parameters:
- N, 32, operand/result width; must be a multiple of SEG.
- SEG, 8, bits resolved per stage; STAGES = N/SEG (1 allowed).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operands valid.
- in_ready  out  1  stage 0 can accept this cycle.
- a  in  N  minuend, two's complement or unsigned.
- b  in  N  subtrahend.
- bin  in  1  borrow-in.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- diff  out  N  A - B - bin, modulo 2^N.
- borrow  out  1  unsigned borrow-out = ~carry_out.
- overflow  out  1  signed overflow: a[N-1] != b[N-1] && diff[N-1] != a[N-1].
- zero  out  1  diff == 0.

Behaviour:
- Reset (async, immediate): all stage valid bits clear. out_valid=0, diff=0, borrow=0, overflow=0, zero=0. in_ready=1 combinationally once rst deasserts.
- Stage k (0..STAGES-1) holds:
  - valid bit v[k];
  - resolved diff bits [(k+1)*SEG-1:0];
  - carry into segment k+1;
  - unresolved upper bits of a and ~b;
  - a[N-1] and b[N-1].
- Stage k computes segment k with cla_segment. Carry-in is ~bin for k=0, otherwise the registered carry from stage k-1.
- Flow control is a per-stage bubble-collapsing chain:
  - en[STAGES] = out_ready;
  - en[k] = ~v[k] | en[k+1];
  - in_ready = en[0].
- Stage k loads from stage k-1 (or from the inputs for k=0) when en[k]=1. It sets v[k] to the upstream valid, so a bubble propagates as v=0.
- in_ready is combinational from out_ready. No registered skid buffer.
- Latency: operand accepted on edge t gives out_valid=1 after edge t+STAGES-1. With STAGES=4, that is 4 edges counting edge t.
- Throughput: one result per cycle while out_ready=1.
- Output stage behaviour:
  - diff, borrow, overflow and zero come from the registers of the last stage.
  - borrow = ~(carry out of the MSB segment).
  - zero is evaluated on the full registered difference.
  - Outputs hold stable while out_valid=1 and out_ready=0.
  - Outputs may change only on a transfer, or while out_valid=0.
- Boundary conditions:
  - Pipeline full with out_ready=0: every en=0, in_ready=0, nothing moves, no data lost.
  - Simultaneous accept at input and output when full: allowed, all stages shift.
  - Results emerge strictly in acceptance order.
  - Reset mid-operation discards all in-flight results; no partial output appears.
- Arithmetic is exact modulo 2^N. a = b with bin=1 gives all-ones, borrow=1.

Decomposition:
- Shared package holds:
  - default N and SEG;
  - localparam STAGES = N/SEG;
  - an elaboration check that N % SEG == 0 and SEG >= 1.
- Sub-module cla_segment (combinational):
  - inputs x[SEG], y[SEG], cin;
  - outputs s[SEG], cout;
  - internal generate g=x&y, propagate p=x|y, lookahead carry chain.
- Top module instantiates one cla_segment per stage in a generate loop.

Test Plan (N=32, SEG=8):
- a=5, b=3, bin=0, out_ready=1 → after 4 edges: diff=2, borrow=0, overflow=0, zero=0.
- a=3, b=5, bin=0 → diff=0xFFFFFFFE, borrow=1, overflow=0.
- a=0x80000000, b=1, bin=0 → diff=0x7FFFFFFF, overflow=1, borrow=0. Also a=0x7FFFFFFF, b=0xFFFFFFFF → diff=0x80000000, overflow=1, borrow=1.
- a=7, b=7, bin=0 → zero=1, borrow=0. Then a=7, b=7, bin=1 → diff=0xFFFFFFFF, borrow=1, zero=0.
- Back-to-back stream:
  - stimulus: 8 pairs (a=i*100, b=i) with in_valid held high; drop out_ready to 0 after 2 results for 6 cycles, then raise it;
  - required: in_ready=0 once 4 stages are full; held outputs stable; all 8 results correct and in order; no duplicates.
- Reset mid-operation: assert rst with 3 operands in flight → out_valid=0 immediately, no stale result appears after release, and a new operand gives a correct result 4 edges later.

Source files
------------

// File: rtl/pipelined_cla_subtractor_pkg.sv
// pipelined_cla_subtractor_pkg: shared widths, stage count and configuration check
package pipelined_cla_subtractor_pkg;
    localparam int N_DEF   = 32;
    localparam int SEG_DEF = 8;
    localparam int STAGES  = N_DEF / SEG_DEF;
    function automatic bit cfg_ok(input int n, input int seg);
        return seg >= 1 && n % seg == 0;
    endfunction
endpackage

// File: rtl/pipelined_cla_subtractor_cla_segment.sv
// cla_segment: combinational SEG-bit carry-lookahead adder slice
//   x, y : addend bits      cin  : carry into bit 0
//   s    : sum bits         cout : carry out of the top bit
module cla_segment
    import pipelined_cla_subtractor_pkg::*;
#(
    parameter int SEG = SEG_DEF
) (
    input  logic [SEG-1:0] x,
    input  logic [SEG-1:0] y,
    input  logic           cin,
    output logic [SEG-1:0] s,
    output logic           cout
);
    logic [SEG-1:0] g, p;
    logic [SEG:0]   c;
    logic           t, pp;
    assign g = x & y;
    assign p = x | y;
    // Each carry is a flat sum of products over the generates below it and cin,
    // so no carry waits on another carry.
    always_comb begin
        c = '0;
        t = 1'b0;
        pp = 1'b0;
        c[0] = cin;
        for (int i = 0; i < SEG; i++) begin
            t = g[i];
            pp = p[i];
            for (int j = i - 1; j >= 0; j--) begin
                t = t | (pp & g[j]);
                pp = pp & p[j];
            end
            c[i+1] = t | (pp & cin);
        end
    end
    assign s    = x ^ y ^ c[SEG-1:0];
    assign cout = c[SEG];
endmodule

// File: rtl/pipelined_cla_subtractor.sv
// pipelined_cla_subtractor: streaming A - B - bin, one SEG-bit segment per stage
//   clk, rst            : clock, async active-high reset
//   in_valid/in_ready   : operand handshake (a, b, bin)
//   out_valid/out_ready : result handshake (diff, borrow, overflow, zero)
module pipelined_cla_subtractor
    import pipelined_cla_subtractor_pkg::*;
#(
    parameter int N   = N_DEF,
    parameter int SEG = SEG_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         bin,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] diff,
    output logic         borrow,
    output logic         overflow,
    output logic         zero
);
    localparam int S = N / SEG;
    if (!cfg_ok(N, SEG)) begin : g_cfg
        $error("pipelined_cla_subtractor: N must be a positive multiple of SEG");
    end
    logic [S-1:0] v, c, sa, sb;
    logic [S:0]   en;
    // w and nb rotate right by SEG each stage: the next segment's operand bits sit
    // at [SEG-1:0] while resolved diff bits enter from the top, so after S stages
    // w holds the difference in natural order.
    logic [N-1:0] w  [S];
    logic [N-1:0] nb [S];
    always_comb begin
        en = '0;
        en[S] = out_ready;
        for (int k = S - 1; k >= 0; k--) en[k] = ~v[k] | en[k+1];
    end
    assign in_ready = en[0];
    for (genvar k = 0; k < S; k++) begin : g_st
        logic [N-1:0]   wi, nbi;
        logic           ci, vi, sai, sbi, co;
        logic [SEG-1:0] s;
        if (k == 0) begin : g_src
            assign wi  = a;
            assign nbi = ~b;
            assign ci  = ~bin;
            assign vi  = in_valid;
            assign sai = a[N-1];
            assign sbi = b[N-1];
        end else begin : g_src
            assign wi  = w[k-1];
            assign nbi = nb[k-1];
            assign ci  = c[k-1];
            assign vi  = v[k-1];
            assign sai = sa[k-1];
            assign sbi = sb[k-1];
        end
        cla_segment #(.SEG(SEG)) u_seg (
            .x(wi[SEG-1:0]),
            .y(nbi[SEG-1:0]),
            .cin(ci),
            .s(s),
            .cout(co)
        );
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                v[k]  <= 1'b0;
                w[k]  <= '0;
                nb[k] <= '0;
                c[k]  <= 1'b0;
                sa[k] <= 1'b0;
                sb[k] <= 1'b0;
            end else if (en[k]) begin
                v[k]  <= vi;
                w[k]  <= N'({s, wi} >> SEG);
                nb[k] <= N'({nbi, nbi} >> SEG);
                c[k]  <= co;
                sa[k] <= sai;
                sb[k] <= sbi;
            end
        end
    end
    // Flags are qualified by the last valid bit so an empty pipeline reads all-zero.
    assign out_valid = v[S-1];
    assign diff      = w[S-1];
    assign borrow    = v[S-1] & ~c[S-1];
    assign overflow  = v[S-1] & (sa[S-1] ^ sb[S-1]) & (diff[N-1] ^ sa[S-1]);
    assign zero      = v[S-1] & ~|diff;
endmodule
